gshare_ctrl: RTL
================

# gshare_ctrl

Branch-prediction controller that sequences the pattern history table (PHT) for the in-order pipeline. It owns the speculative and committed global history registers (GHR) and forms the PHT read index at fetch. It tracks in-flight predicted branches until execute resolves them, then issues the PHT counter update and recovers history on a mispredict. It sits between fetch, execute and the PHT storage, which exposes a read index, a predicted-taken bit and an explicit write port.

## Interface
- NUM_GHR_BITS, 5, GHR width and PHT index width; must be ≥2.
- QUEUE_DEPTH, 4, maximum in-flight predicted branches; must be a power of 2 and ≥2.
- clk  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- fetch_valid_i  in  1  fetch holds a conditional branch needing a prediction.
- fetch_pc_i  in  32  PC of that branch.
- stall_i  in  1  front-end stall; no prediction is accepted this cycle.
- pht_taken_i  in  1  predict bit returned by the PHT for pht_raddr_o.
- pht_raddr_o  out  NUM_GHR_BITS  PHT read index.
- predict_taken_o  out  1  prediction returned to fetch.
- pred_ready_o  out  1  controller can accept a prediction this cycle.
- resolve_valid_i  in  1  execute resolves the oldest outstanding branch.
- resolve_taken_i  in  1  actual branch outcome.
- pht_wen_o  out  1  PHT update strobe.
- pht_waddr_o  out  NUM_GHR_BITS  PHT update index.
- pht_increment_o  out  1  1 = increment the counter, 0 = decrement it.
- mispredict_o  out  1  one-cycle pulse that requests a front-end flush.
- ghr_o  out  NUM_GHR_BITS  speculative GHR.
- inflight_count_o  out  $clog2(QUEUE_DEPTH+1)  number of queued branches.

## Operation
- Registers: spec_ghr, arch_ghr, the in-flight FIFO (QUEUE_DEPTH entries of {idx, pred}), and FSM state {RUN, RECOVER}. All are cleared by reset.
- Index: pht_raddr_o = spec_ghr, XORed with fetch_pc_i[NUM_GHR_BITS+1:2] when the Configuration macro is defined. The index is combinational every cycle.
- predict_taken_o = fetch_valid_i & pht_taken_i.
- pred_ready_o = (state==RUN) & ~full. Full is taken from registered state only; a pop in the same cycle does not free a slot.
- Accept condition: fetch_valid_i & ~stall_i & pred_ready_o & ~mispredict_now.
  - Push {pht_raddr_o, predict_taken_o} into the FIFO.
  - spec_ghr <= {spec_ghr[N-2:0], predict_taken_o}.
- Resolve condition: resolve_valid_i & non-empty FIFO.
  - Pop the head entry.
  - arch_ghr <= {arch_ghr[N-2:0], resolve_taken_i}.
  - Next cycle: pht_wen_o=1, pht_waddr_o=head.idx, pht_increment_o=resolve_taken_i.
- mispredict_now = resolve condition & (resolve_taken_i != head.pred). When set:
  - FIFO is flushed, so the count becomes 0.
  - spec_ghr <= {arch_ghr[N-2:0], resolve_taken_i}.
  - Any same-cycle accept is discarded.
  - mispredict_o=1 next cycle.
  - State goes to RECOVER.
- FSM: RUN→RECOVER on mispredict_now; RECOVER→RUN unconditionally after one cycle. In RECOVER, pred_ready_o=0. Resolves in RECOVER see an empty FIFO and are ignored.
- resolve_valid_i with an empty FIFO: ignored; no PHT write, no GHR change.
- Push and pop in the same cycle (correct prediction): both happen; the count is unchanged.
- FIFO pointers wrap modulo QUEUE_DEPTH. The count saturates neither high nor low because the guards above prevent overflow and underflow.
- Reset values: pht_wen_o=0, pht_waddr_o=0, pht_increment_o=0, mispredict_o=0, ghr_o=0, inflight_count_o=0, pred_ready_o=1. Outputs that follow fetch_pc_i or fetch_valid_i combinationally stay combinational under reset.

## Timing
- Prediction: 0-cycle (combinational) from fetch_pc_i to pht_raddr_o. spec_ghr updates on the accepting edge.
- PHT update: registered, asserted the cycle after resolve and high for exactly one cycle per resolve.
- Mispredict: mispredict_o and the restored ghr_o are visible the cycle after the resolve. The earliest next accept is 2 cycles after the resolve.
- Reset asserted mid-operation clears all state on the next edge. No PHT write is issued for entries lost to reset.

## Configuration
- GSHARE_PC_XOR_EN defined: gshare indexing, spec_ghr ^ fetch_pc_i[NUM_GHR_BITS+1:2].
- GSHARE_PC_XOR_EN undefined: global-history-only indexing, pht_raddr_o = spec_ghr; fetch_pc_i is unused.

## Structure
- Shared package bp_pkg:
  - State enum {RUN, RECOVER}.
  - In-flight entry struct {idx, pred}, parameterised by NUM_GHR_BITS.
  - Default-width constants.
- Sub-module bp_inflight_fifo: synchronous FIFO with push, pop and flush inputs, and full, empty and count outputs.

## Test plan
- Reset, then 4 accepted predictions with pht_taken_i=1 and no stall → ghr_o=5'b01111, inflight_count_o=4, pred_ready_o=0.
- Correct resolve (head.pred=1, resolve_taken_i=1) → next cycle pht_wen_o=1, pht_increment_o=1, pht_waddr_o=head.idx; mispredict_o=0; count drops by 1.
- 3 in flight with arch_ghr=5'b00010, head.pred=1 and resolve_taken_i=0 → next cycle mispredict_o=1, ghr_o=5'b00100, count=0, pht_increment_o=0; pred_ready_o=0 for that one RECOVER cycle.
- fetch_valid_i, resolve_valid_i and a mispredict in the same cycle → the push is discarded and the count is 0 afterwards.
- resolve_valid_i with an empty FIFO → pht_wen_o stays 0 and ghr_o is unchanged.
- With GSHARE_PC_XOR_EN, spec_ghr=5'b10101 and fetch_pc_i=32'h0000_0044 → pht_raddr_o=5'b00100. Without the macro → pht_raddr_o=5'b10101.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and default sizes for the gshare branch-prediction controller.
// The PC-XOR indexing option is selected with the GSHARE_PC_XOR_EN macro in gshare_ctrl.
package bp_pkg;

  localparam int BP_DEFAULT_GHR_BITS    = 5;
  localparam int BP_DEFAULT_QUEUE_DEPTH = 4;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bp_state_e;

  // Default-width view of an in-flight entry; gshare_ctrl declares the sized copy.
  typedef struct packed {
    logic [BP_DEFAULT_GHR_BITS-1:0] idx;
    logic                           pred;
  } bp_entry_t;

  function automatic int bp_entry_width(input int ghr_bits);
    return ghr_bits + 1;
  endfunction

endpackage

// File: rtl/bp_inflight_fifo.sv
// Synchronous FIFO holding predicted branches until execute resolves them.
// Flush wins over push and pop; pointers wrap modulo DEPTH (a power of 2).
module bp_inflight_fifo
  import bp_pkg::*;
#(
  parameter int WIDTH = bp_entry_width(BP_DEFAULT_GHR_BITS),
  parameter int DEPTH = BP_DEFAULT_QUEUE_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data_i;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/gshare_ctrl.sv
// Gshare controller: speculative/committed GHR, PHT index, in-flight tracking and recovery.
// Define GSHARE_PC_XOR_EN to XOR fetch_pc_i[N+1:2] into the PHT read index.
//
// Handshake: a prediction is accepted when fetch_valid_i & ~stall_i & pred_ready_o and no
// mispredict is being taken that cycle; a resolve is consumed when resolve_valid_i and the
// in-flight FIFO is non-empty. There is no backpressure on resolve.
module gshare_ctrl
  import bp_pkg::*;
#(
  parameter int NUM_GHR_BITS = BP_DEFAULT_GHR_BITS,
  parameter int QUEUE_DEPTH  = BP_DEFAULT_QUEUE_DEPTH,
  localparam int CW          = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic                    fetch_valid_i,
  input  logic [31:0]             fetch_pc_i,
  input  logic                    stall_i,
  input  logic                    pht_taken_i,
  output logic [NUM_GHR_BITS-1:0] pht_raddr_o,
  output logic                    predict_taken_o,
  output logic                    pred_ready_o,
  input  logic                    resolve_valid_i,
  input  logic                    resolve_taken_i,
  output logic                    pht_wen_o,
  output logic [NUM_GHR_BITS-1:0] pht_waddr_o,
  output logic                    pht_increment_o,
  output logic                    mispredict_o,
  output logic [NUM_GHR_BITS-1:0] ghr_o,
  output logic [CW-1:0]           inflight_count_o
);

  localparam int N = NUM_GHR_BITS;

  typedef struct packed {
    logic [N-1:0] idx;
    logic         pred;
  } entry_t;

  bp_state_e    state_q, state_d;
  logic [N-1:0] spec_ghr_q, spec_ghr_d;
  logic [N-1:0] arch_ghr_q, arch_ghr_d;
  logic         pht_wen_q, pht_wen_d;
  logic [N-1:0] pht_waddr_q, pht_waddr_d;
  logic         pht_inc_q, pht_inc_d;
  logic         mispredict_q, mispredict_d;

  entry_t       head, push_entry;
  logic         fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic         resolve_fire, mispredict_now, accept;
  logic         unused_pc;

  assign unused_pc = ^fetch_pc_i;

`ifdef GSHARE_PC_XOR_EN
  assign pht_raddr_o = spec_ghr_q ^ fetch_pc_i[N+1:2];
`else
  assign pht_raddr_o = spec_ghr_q;
`endif

  assign predict_taken_o = fetch_valid_i & pht_taken_i;
  assign pred_ready_o    = (state_q == RUN) & ~fifo_full;

  assign resolve_fire   = resolve_valid_i & ~fifo_empty;
  assign mispredict_now = resolve_fire & (resolve_taken_i != head.pred);
  assign accept         = fetch_valid_i & ~stall_i & pred_ready_o & ~mispredict_now;

  assign push_entry = '{idx: pht_raddr_o, pred: predict_taken_o};

  bp_inflight_fifo #(
    .WIDTH (bp_entry_width(N)),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset_i     (reset_i),
    .push_i      (accept),
    .push_data_i (push_entry),
    .pop_i       (resolve_fire),
    .flush_i     (mispredict_now),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  always_comb begin
    spec_ghr_d   = spec_ghr_q;
    arch_ghr_d   = arch_ghr_q;
    pht_wen_d    = resolve_fire;
    pht_waddr_d  = pht_waddr_q;
    pht_inc_d    = pht_inc_q;
    mispredict_d = mispredict_now;
    state_d      = RUN;

    if (resolve_fire) begin
      arch_ghr_d  = {arch_ghr_q[N-2:0], resolve_taken_i};
      pht_waddr_d = head.idx;
      pht_inc_d   = resolve_taken_i;
    end

    // Recovery restarts speculation from the committed history plus the real outcome.
    if (mispredict_now) begin
      spec_ghr_d = {arch_ghr_q[N-2:0], resolve_taken_i};
      state_d    = RECOVER;
    end else if (accept) begin
      spec_ghr_d = {spec_ghr_q[N-2:0], predict_taken_o};
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q      <= RUN;
      spec_ghr_q   <= '0;
      arch_ghr_q   <= '0;
      pht_wen_q    <= 1'b0;
      pht_waddr_q  <= '0;
      pht_inc_q    <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      spec_ghr_q   <= spec_ghr_d;
      arch_ghr_q   <= arch_ghr_d;
      pht_wen_q    <= pht_wen_d;
      pht_waddr_q  <= pht_waddr_d;
      pht_inc_q    <= pht_inc_d;
      mispredict_q <= mispredict_d;
    end
  end

  assign pht_wen_o        = pht_wen_q;
  assign pht_waddr_o      = pht_waddr_q;
  assign pht_increment_o  = pht_inc_q;
  assign mispredict_o     = mispredict_q;
  assign ghr_o            = spec_ghr_q;
  assign inflight_count_o = fifo_count;

endmodule
